// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit that owns the HI/LO register pair.
// Signed operations run on magnitudes; signs are reapplied in one fix-up cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [CW-1:0]      cnt_r, cnt_s;
    logic               is_div_r, is_div_s;
    logic               neg_q_r, neg_q_s;
    logic               neg_r_r, neg_r_s;
    logic               b_zero_r, b_zero_s;
    logic [WIDTH-1:0]   a_raw_r, a_raw_s;
    logic [WIDTH-1:0]   opnd_r, opnd_s;
    logic [2*WIDTH-1:0] acc_r, acc_s;
    logic [WIDTH-1:0]   hi_r, hi_s;
    logic [WIDTH-1:0]   lo_r, lo_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;
    logic               div_zero_r, div_zero_s;

    logic               a_neg_s, b_neg_s;
    logic [WIDTH-1:0]   a_abs_s, b_abs_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [2*WIDTH-1:0] mul_step_s;
    logic [WIDTH:0]     div_sh_s;
    logic [WIDTH-1:0]   div_diff_s;
    logic [2*WIDTH-1:0] div_step_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s, rem_s;

    assign a_neg_s = ~op[0] & a[WIDTH-1];
    assign b_neg_s = ~op[0] & b[WIDTH-1];
    assign a_abs_s = a_neg_s ? ({WIDTH{1'b0}} - a) : a;
    assign b_abs_s = b_neg_s ? ({WIDTH{1'b0}} - b) : b;

    // Multiply: {acc_hi, multiplier} shifts right, adding the multiplicand on a set LSB.
    assign mul_sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, opnd_r};
    assign mul_step_s = acc_r[0] ? {mul_sum_s, acc_r[WIDTH-1:1]}
                                 : {1'b0, acc_r[2*WIDTH-1:1]};

    // Divide: {remainder, dividend/quotient} shifts left; restore when the trial subtract underflows.
    assign div_sh_s   = acc_r[2*WIDTH-1:WIDTH-1];
    assign div_diff_s = div_sh_s[WIDTH-1:0] - opnd_r;
    assign div_step_s = (div_sh_s >= {1'b0, opnd_r})
                        ? {div_diff_s, acc_r[WIDTH-2:0], 1'b1}
                        : {div_sh_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};

    assign prod_s = neg_q_r ? ({(2*WIDTH){1'b0}} - acc_r) : acc_r;
    assign quo_s  = neg_q_r ? ({WIDTH{1'b0}} - acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
    assign rem_s  = neg_r_r ? ({WIDTH{1'b0}} - acc_r[2*WIDTH-1:WIDTH]) : acc_r[2*WIDTH-1:WIDTH];

    // Next-state and next-register computation for the IDLE/CALC/FIX sequencer.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        is_div_s   = is_div_r;
        neg_q_s    = neg_q_r;
        neg_r_s    = neg_r_r;
        b_zero_s   = b_zero_r;
        a_raw_s    = a_raw_r;
        opnd_s     = opnd_r;
        acc_s      = acc_r;
        hi_s       = hi_r;
        lo_s       = lo_r;
        done_s     = 1'b0;
        div_zero_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (hi_we) hi_s = wdata; else hi_s = hi_r;
                if (lo_we) lo_s = wdata; else lo_s = lo_r;
                if (start && !flush) begin
                    state_s  = CALC;
                    cnt_s    = {CW{1'b0}};
                    is_div_s = op[1];
                    neg_q_s  = a_neg_s ^ b_neg_s;
                    neg_r_s  = a_neg_s;
                    b_zero_s = (b == {WIDTH{1'b0}});
                    a_raw_s  = a;
                    if (op[1]) begin
                        opnd_s = b_abs_s;
                        acc_s  = {{WIDTH{1'b0}}, a_abs_s};
                    end else begin
                        opnd_s = a_abs_s;
                        acc_s  = {{WIDTH{1'b0}}, b_abs_s};
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (flush) begin
                    state_s = IDLE;
                end else begin
                    if (is_div_r) acc_s = div_step_s; else acc_s = mul_step_s;
                    cnt_s = cnt_r + CW'(1);
                    if (cnt_r == LAST_STEP) state_s = FIX; else state_s = CALC;
                end
            end
            FIX: begin
                state_s = IDLE;
                if (flush) begin
                    done_s = 1'b0;
                end else begin
                    done_s = 1'b1;
                    if (!is_div_r) begin
                        hi_s = prod_s[2*WIDTH-1:WIDTH];
                        lo_s = prod_s[WIDTH-1:0];
                    end else if (b_zero_r) begin
                        hi_s       = a_raw_r;
                        lo_s       = {WIDTH{1'b1}};
                        div_zero_s = 1'b1;
                    end else begin
                        hi_s = rem_s;
                        lo_s = quo_s;
                    end
                end
            end
            default: state_s = IDLE;
        endcase
        busy_s = (state_s != IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            cnt_r      <= {CW{1'b0}};
            is_div_r   <= 1'b0;
            neg_q_r    <= 1'b0;
            neg_r_r    <= 1'b0;
            b_zero_r   <= 1'b0;
            a_raw_r    <= {WIDTH{1'b0}};
            opnd_r     <= {WIDTH{1'b0}};
            acc_r      <= {(2*WIDTH){1'b0}};
            hi_r       <= {WIDTH{1'b0}};
            lo_r       <= {WIDTH{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            is_div_r   <= is_div_s;
            neg_q_r    <= neg_q_s;
            neg_r_r    <= neg_r_s;
            b_zero_r   <= b_zero_s;
            a_raw_r    <= a_raw_s;
            opnd_r     <= opnd_s;
            acc_r      <= acc_s;
            hi_r       <= hi_s;
            lo_r       <= lo_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            div_zero_r <= div_zero_s;
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign div_zero = div_zero_r;
    assign hi       = hi_r;
    assign lo       = lo_r;
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit owning the HI/LO register pair for the MIPS multistage pipeline. It executes MULT, MULTU, DIV and DIVU over WIDTH clock iterations, stalls the pipeline through `busy`, and serves MFHI/MFLO reads and MTHI/MTLO writes. It sits in the EX stage beside the ALU; the datapath drives operands from the forwarded rs/rt values and selects `hi`/`lo` through the HIGH_OUT/LOW_OUT data paths.

## Interface
- WIDTH, 32, operand/HI/LO width; even, ≥ 4.
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request a new operation; sampled only when `busy`=0.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  in  WIDTH  rs operand (multiplicand / dividend).
- b  in  WIDTH  rt operand (multiplier / divisor).
- flush  in  1  abort in-flight operation (exception / ERET).
- hi_we  in  1  MTHI write strobe.
- lo_we  in  1  MTLO write strobe.
- wdata  in  WIDTH  MTHI/MTLO data.
- busy  out  1  operation in progress; pipeline stall request.
- done  out  1  one-cycle pulse: HI/LO just updated by an operation.
- div_zero  out  1  one-cycle pulse with `done` when a divide had `b`=0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- States: IDLE, CALC, FIX. `busy` = (state ≠ IDLE), registered.
- IDLE: accepted start (start=1, flush=0) latches op, absolute values |a|, |b| for signed ops (raw for unsigned), sign flags, iteration counter=0 → CALC.
- CALC: one radix-2 step per cycle. Multiply: shift-add, 2·WIDTH accumulator. Divide: restoring shift-subtract, WIDTH quotient + WIDTH remainder. After WIDTH steps → FIX.
- FIX: apply signs, write HI/LO, pulse `done` → IDLE.
  - MULT/MULTU: {HI,LO} = 2·WIDTH product; negated when sign(a)≠sign(b) for MULT.
  - DIV/DIVU: LO = quotient, HI = remainder. DIV quotient negated if signs differ; remainder takes sign of `a`.
  - Signed most-negative ÷ −1: LO = most-negative value (wraps), HI = 0.
  - Divide by zero: HI = `a` unmodified, LO = all ones, `div_zero`=1 with `done`.
- start while busy: ignored, no queueing.
- hi_we/lo_we: write `wdata` at the edge when busy=0; dropped when busy=1. Same cycle as accepted start: write performed, operation proceeds and later overwrites both registers.
- flush: state → IDLE at next edge from any state; HI/LO unchanged; no `done`. flush with start in IDLE: start dropped.
- Reset: state IDLE, counter 0, hi=lo=0, busy=0, done=0, div_zero=0, datapath registers 0.

## Timing
- Start accepted at edge N: busy=1 after edge N through edge N+WIDTH+1 (WIDTH+1 cycles).
- Iterations on edges N+1…N+WIDTH; HI/LO written at edge N+WIDTH+1.
- `done` (and `div_zero` if applicable) high for exactly the cycle after edge N+WIDTH+1; busy=0 in that cycle, so a new start is accepted at edge N+WIDTH+2 earliest.
- MTHI/MTLO take effect at the sampling edge; hi/lo visible the next cycle.
- Latency identical for all four ops and for divide-by-zero.
- Reset asserted mid-operation clears everything immediately (asynchronous); no `done`.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; busy high 33 cycles, done pulse one cycle after.
- MULT a=−3 (0xFFFFFFFD), b=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB; DIV a=−7, b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU a=0x00001234, b=0 → HI=0x00001234, LO=0xFFFFFFFF, div_zero=1 with done; DIV 0x80000000 ÷ 0xFFFFFFFF → LO=0x80000000, HI=0.
- Prior HI=0x11, LO=0x22; start MULTU, flush at cycle 10 → busy=0 next cycle, HI/LO unchanged, no done; start and hi_we pulsed while busy → ignored.
- MTHI 0xA5A5A5A5 while idle → hi=0xA5A5A5A5 next cycle; MTLO same cycle as start MULTU 2×3 → lo=wdata, then HI=0, LO=6 at done.
- WIDTH=8 instance: MULT 0x80×0x80 → HI=0x40, LO=0x00 after 9 busy cycles; reset deasserted-asserted mid-op → all outputs 0 immediately.
